// File: rtl/div_unit.sv
// Sequential signed restoring divider: quotient on lo_out, remainder on hi_out.
// Optional macro DIV_ZERO_TRAP_EN: a zero divisor finishes at once with div_zero instead of running.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             div_start,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_busy,
  output logic             div_end,
  output logic             div_zero,
  output logic [1:0]       dbg_state_o
);

  // Handshake: div_start is sampled only while idle (div_busy low) and ignored otherwise;
  // div_end is a one-cycle registered pulse, and results stay put until the next div_end.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             end_q;
  logic             zero_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shl_rem;
  logic             take;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_fix;
  logic             trap_hit;

  assign abs_a = a_in[WIDTH-1] ? -a_in : a_in;
  assign abs_b = b_in[WIDTH-1] ? -b_in : b_in;

`ifdef DIV_ZERO_TRAP_EN
  assign trap_hit = (b_in == '0);
`else
  assign trap_hit = 1'b0;
`endif

  // The shifted remainder needs one extra bit; after a conditional subtract it
  // is always below the divisor, so the low WIDTH bits of the difference suffice.
  always_comb begin
    shl_rem = {rem_q, quo_q[WIDTH-1]};
    take    = (shl_rem >= {1'b0, dvs_q});
    rem_d   = take ? (shl_rem[WIDTH-1:0] - dvs_q) : shl_rem[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], take};
  end

  always_comb begin
    lo_fix = q_neg_q ? -quo_q : quo_q;
    hi_fix = r_neg_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      end_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      end_q  <= 1'b0;
      zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            if (trap_hit) begin
              end_q  <= 1'b1;
              zero_q <= 1'b1;
            end else begin
              rem_q   <= '0;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              q_neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              r_neg_q <= a_in[WIDTH-1];
              cnt_q   <= CW'(WIDTH);
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          lo_q    <= lo_fix;
          hi_q    <= hi_fix;
          end_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_busy    = (state_q != S_IDLE);
  assign div_end     = end_q;
  assign div_zero    = zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: a driver pushes expected results,
// a negedge monitor pops and compares them when div_end fires.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         div_start;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         div_busy;
  logic         div_end;
  logic         div_zero;
  logic [1:0]   dbg_state;

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_in        (a_in),
    .b_in        (b_in),
    .div_start   (div_start),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_busy    (div_busy),
    .div_end     (div_end),
    .div_zero    (div_zero),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         zero;
    logic         keep;     // results must stay at their previous values
    logic [31:0]  end_cyc;  // cycle count at which div_end is seen
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] hold_lo = '0;
  logic [W-1:0] hold_hi = '0;
  int           busy_lo = 0;
  int           busy_hi = 0;
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS div semantics from plain signed 64-bit arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    exp_t   e;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.keep    = 1'b0;
    e.zero    = 1'b0;
    e.end_cyc = 32'(n + 34);
    e.lo      = '0;
    e.hi      = '0;
    if (sb == 0) begin
`ifdef DIV_ZERO_TRAP_EN
      e.keep    = 1'b1;
      e.zero    = 1'b1;
      e.end_cyc = 32'(n + 1);
`else
      e.lo = (sa < 0) ? W'(1) : {W{1'b1}};
      e.hi = a;
`endif
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.lo = q[W-1:0];
      e.hi = r[W-1:0];
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(a, b, cyc);
    exp_q.push_back(e);
    busy_lo = cyc;
    busy_hi = e.keep ? cyc + 1 : cyc + 34;
  endtask

  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    @(negedge clk);
    a_in = a;
    b_in = b;
    div_start = 1'b1;
    push(a, b);
    @(posedge clk);
    #1;
    if (!hold) div_start = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d results outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
    start_div(a, b, 1'b0);
    wait_idle();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      check("busy", W'(div_busy), W'(cyc > busy_lo && cyc < busy_hi));
      if (exp_q.size() != 0 && cyc > int'(exp_q[0].end_cyc) && !div_end) begin
        checks++;
        failures++;
        $display("FAIL missing_end: div_end=0 expected 1 at cycle %0d", exp_q[0].end_cyc);
        void'(exp_q.pop_front());
      end
      if (div_end) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_end: div_end=1 expected 0 at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check("end_cycle", W'(cyc), e.end_cyc);
          check("div_zero", W'(div_zero), W'(e.zero));
          if (!e.keep) begin
            hold_lo = e.lo;
            hold_hi = e.hi;
          end
          check("lo", lo_out, hold_lo);
          check("hi", hi_out, hold_hi);
        end
      end else begin
        check("zero_idle", W'(div_zero), '0);
        check("lo_hold", lo_out, hold_lo);
        check("hi_hold", hi_out, hold_hi);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [W-1:0] ra, rb;
    reset = 1'b1;
    div_start = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_lo", lo_out, '0);
    check("rst_hi", hi_out, '0);
    check("rst_busy", W'(div_busy), '0);
    check("rst_end", W'(div_end), '0);
    check("rst_zero", W'(div_zero), '0);
    check("rst_state", W'(dbg_state), '0);
    @(posedge clk);
    #1 reset = 1'b0;

    // signs and the overflow corner
    run_one(32'd100, 32'd7);
    run_one(-32'sd100, 32'd7);
    run_one(32'd100, -32'sd7);
    run_one(-32'sd100, -32'sd7);
    run_one(32'h8000_0000, 32'hFFFF_FFFF);
    run_one(32'h8000_0000, 32'd1);
    run_one(32'h8000_0000, 32'h8000_0000);

    // divide by zero after a known result
    run_one(32'd100, 32'd7);
    run_one(32'd5, 32'd0);
    run_one(-32'sd5, 32'd0);

    // re-pulse while busy must be ignored
    start_div(32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    a_in = 32'd9;
    b_in = 32'd3;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    wait_idle();

    // reset in the middle of a run discards it
    start_div(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_lo", lo_out, '0);
    check("midrst_hi", hi_out, '0);
    check("midrst_busy", W'(div_busy), '0);
    check("midrst_end", W'(div_end), '0);
    exp_q.delete();
    hold_lo = '0;
    hold_hi = '0;
    busy_lo = 0;
    busy_hi = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);

    // div_start held high across div_end starts the next division immediately
    start_div(32'd1000, 32'd33, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!div_end && n < 40);
    if (!div_end) begin
      checks++;
      failures++;
      $display("FAIL b2b_end: div_end=0 expected 1 within 40 cycles");
    end
    a_in = -32'sd77;
    b_in = 32'd5;
    push(a_in, b_in);
    @(posedge clk);
    #1 div_start = 1'b0;
    wait_idle();

    // randomized operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 15);
        2: rb = -$urandom_range(1, 15);
        3: rb = (i % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
        default: begin
          ra = {1'b1, 31'($urandom_range(0, 3))};
          rb = $urandom;
        end
      endcase
      run_one(ra, rb);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
